// File: rtl/fir_tb_pkg.sv
// ---------------------------------------------------------------------------
// fir_tb_pkg : shared widths, LFSR constants and FSM states for the FIR
//              sample source.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_tb_pkg;

  localparam int NB_DEF     = 9;
  localparam int N_TAPS_DEF = 9;

  // x^9 + x^5 + 1, taps given as 1-based polynomial exponents
  localparam int LFSR_W     = 9;
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 5;
  localparam logic [LFSR_W-1:0] LFSR_FALLBACK_SEED = 9'h001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/fir_lfsr.sv
// ---------------------------------------------------------------------------
// fir_lfsr : 9-bit Fibonacci LFSR, advances only when EN is high.
//            Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_lfsr
  import fir_tb_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic [LFSR_W-1:0] SEED,
  output logic [LFSR_W-1:0] Q
);

  logic [LFSR_W-1:0] seed_eff;
  logic [LFSR_W-1:0] lfsr_d;
  logic [LFSR_W-1:0] lfsr_q;

  // An all-zero state would lock the register, so substitute a legal seed.
  always_comb begin
    seed_eff = (SEED == '0) ? LFSR_FALLBACK_SEED : SEED;
    lfsr_d   = lfsr_q;
    if (EN) begin
      lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_A-1] ^ lfsr_q[LFSR_TAP_B-1]};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      lfsr_q <= seed_eff;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign Q = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/fir_stream_source.sv
// ---------------------------------------------------------------------------
// fir_stream_source : streams N_SAMPLES LFSR samples with a valid strobe plus a
//   constant coefficient vector, then drains and flags END_SIM.
//   Optional macro THROTTLE_EN inserts a bubble after every GAP_PERIOD samples.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_stream_source
  import fir_tb_pkg::*;
#(
  parameter int                      NB           = NB_DEF,
  parameter int                      N_TAPS       = N_TAPS_DEF,
  parameter int                      N_SAMPLES    = 256,
  parameter int                      DRAIN_CYCLES = 32,
  parameter logic [LFSR_W-1:0]       SEED         = 9'h001,
  parameter logic [N_TAPS*NB-1:0]    COEFF_INIT   = '0
`ifdef THROTTLE_EN
  ,
  parameter int                      GAP_PERIOD   = 4
`endif
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic [NB-1:0]        DOUT,
  output logic                 VOUT,
  output logic [N_TAPS*NB-1:0] COEFFS,
  output logic                 BUSY,
  output logic [15:0]          SAMPLE_CNT,
  output logic                 END_SIM
);

  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  state_e            state_q, state_d;
  logic [NB-1:0]     dout_q, dout_d;
  logic              vout_q, vout_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic              issue;
  logic              lfsr_en;
  logic [LFSR_W-1:0] lfsr_s;

  fir_lfsr u_lfsr (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (lfsr_en),
    .SEED (SEED),
    .Q    (lfsr_s)
  );

`ifdef THROTTLE_EN
  localparam int GW = $clog2(GAP_PERIOD + 1);

  logic [GW-1:0] gap_q, gap_d;

  // gap_q == GAP_PERIOD marks the bubble slot; the final sample leaves STREAM
  // before a bubble can follow it.
  always_comb begin
    issue = (gap_q != GW'(GAP_PERIOD));
    gap_d = gap_q;
    if (state_q == STREAM) begin
      gap_d = issue ? gap_q + GW'(1) : '0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  assign issue = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    dout_d  = dout_q;
    vout_d  = 1'b0;
    cnt_d   = cnt_q;
    drain_d = drain_q;
    lfsr_en = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (START) state_d = STREAM;
      end
      STREAM: begin
        if (issue) begin
          vout_d  = 1'b1;
          lfsr_en = 1'b1;
          dout_d  = NB'($signed(lfsr_s));
          cnt_d   = cnt_q + 16'd1;
          if (cnt_q == 16'(N_SAMPLES - 1)) state_d = DRAIN;
        end
      end
      // One extra DRAIN cycle carries the final valid, giving DRAIN_CYCLES idle cycles.
      DRAIN: begin
        if (drain_q == DW'(DRAIN_CYCLES)) begin
          state_d = DONE;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dout_q  <= '0;
      vout_q  <= 1'b0;
      cnt_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      dout_q  <= dout_d;
      vout_q  <= vout_d;
      cnt_q   <= cnt_d;
      drain_q <= drain_d;
    end
  end

  assign DOUT       = dout_q;
  assign VOUT       = vout_q;
  assign COEFFS     = COEFF_INIT;
  assign BUSY       = (state_q == STREAM) || (state_q == DRAIN);
  assign SAMPLE_CNT = cnt_q;
  assign END_SIM    = (state_q == DONE);

endmodule

`default_nettype wire

// File: tb/tb_fir_stream_source.sv
// ---------------------------------------------------------------------------
// tb_fir_stream_source : self-checking bench for fir_stream_source.
//   Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_stream_source;

  localparam int NB           = 9;
  localparam int N_TAPS       = 9;
  localparam int N_SAMPLES    = 256;
  localparam int DRAIN_CYCLES = 32;
  localparam logic [8:0]  SEED       = 9'h001;
  localparam logic [80:0] COEFF_INIT = {9'h1A5, 72'h0123_4567_89AB_CDEF_01};
`ifdef THROTTLE_EN
  localparam int GAP        = 4;
  localparam int STREAM_LEN = N_SAMPLES + (N_SAMPLES - 1) / GAP;
`else
  localparam int GAP        = N_SAMPLES;
  localparam int STREAM_LEN = N_SAMPLES;
`endif
  localparam int END_T = STREAM_LEN + DRAIN_CYCLES + 1;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [8:0]  dout;
  logic        vout;
  logic [80:0] coeffs;
  logic        busy;
  logic [15:0] sample_cnt;
  logic        end_sim;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_samples [N_SAMPLES];
  logic [8:0] golden7 [7] = '{9'h001, 9'h002, 9'h004, 9'h008, 9'h010, 9'h021, 9'h042};
  logic [8:0] obs_q [$];
  int pulses;

  fir_stream_source #(
    .NB           (NB),
    .N_TAPS       (N_TAPS),
    .N_SAMPLES    (N_SAMPLES),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .SEED         (SEED),
    .COEFF_INIT   (COEFF_INIT)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .START      (start),
    .DOUT       (dout),
    .VOUT       (vout),
    .COEFFS     (coeffs),
    .BUSY       (busy),
    .SAMPLE_CNT (sample_cnt),
    .END_SIM    (end_sim)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_vout"}, 32'(vout), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_cnt"},  32'(sample_cnt), 32'h0);
    chk({tag, "_end"},  32'(end_sim), 32'h0);
    checks++;
    assert (coeffs === COEFF_INIT) else begin
      errors++;
      $error("FAIL %s_coeffs: observed=%h expected=%h", tag, coeffs, COEFF_INIT);
    end
  endtask

  // Cycle-accurate scoreboard for one run; abort_at>0 stops once that many
  // samples have been seen so the caller can reset mid-run.
  task automatic run(input int abort_at);
    int   idle;
    int   exp_cnt;
    bit   exp_v;
    logic [8:0] exp_d;
    idle = $urandom_range(1, 6);
    obs_q.delete();
    pulses = 0;
    repeat (idle) begin
      step();
      chk("idle_busy", 32'(busy), 32'h0);
      chk("idle_vout", 32'(vout), 32'h0);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_vout", 32'(vout), 32'h0);
    exp_cnt = 0;
    for (int t = 1; t <= END_T + 10; t++) begin
      start = (t >= END_T - 1) ? 1'b1 : 1'($urandom_range(0, 1));
      step();
      exp_v = (t <= STREAM_LEN) && (((t - 1) % (GAP + 1)) != GAP);
      if (exp_v) exp_cnt++;
      exp_d = (exp_cnt == 0) ? 9'h000 : exp_samples[exp_cnt-1];
      chk("vout",    32'(vout),       32'(exp_v));
      chk("dout",    32'(dout),       32'(exp_d));
      chk("cnt",     32'(sample_cnt), 32'(exp_cnt));
      chk("busy",    32'(busy),       32'(t < END_T));
      chk("end_sim", 32'(end_sim),    32'(t >= END_T));
      if (vout === 1'b1) begin
        pulses++;
        if (obs_q.size() < 7) obs_q.push_back(dout);
      end
      if (abort_at != 0 && exp_cnt == abort_at) break;
    end
    start = 1'b0;
  endtask

  initial begin
    int s;
    s = 1;
    for (int i = 0; i < N_SAMPLES; i++) begin
      exp_samples[i] = 9'(s);
      s = ((s << 1) & 'h1FF) | (((s >> 8) ^ (s >> 4)) & 1);
    end

    // Reset with the clock stopped
    #2 rst = 1'b1;
    #1 chk_cleared("reset");
    clk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Full run with random START noise, then START held high in DONE
    run(0);
    chk("run1_pulses", 32'(pulses), 32'(N_SAMPLES));
    chk("run1_final_cnt", 32'(sample_cnt), 32'(N_SAMPLES));
    for (int i = 0; i < 7; i++) chk("run1_seq", 32'(obs_q[i]), 32'(golden7[i]));

    // Abort at sample 100 with an asynchronous reset between edges
    rst = 1'b1;
    #1 chk_cleared("done_reset");
    step();
    rst = 1'b0;
    run(100);
    chk("run2_pulses", 32'(pulses), 32'd100);
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1 chk_cleared("midrun_reset");
    step();
    rst = 1'b0;

    // Restart: sequence and counter start over
    run(0);
    chk("run3_pulses", 32'(pulses), 32'(N_SAMPLES));
    chk("run3_first", 32'(obs_q[0]), 32'h001);
    for (int i = 1; i < 7; i++) chk("run3_seq", 32'(obs_q[i]), 32'(golden7[i]));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
